// File: rtl/bip_cpu.sv
// BIP-I accumulator core: fetch/decode/execute against a combinational program
// memory, driving a DataMemory port. Optional cycle counter under BIP_CYCLE_COUNT_EN.
//
// state   | meaning
// EXEC    | decode instr; immediate/STO/NOP retire here, LD/ADD/SUB issue Rd
// MEMWAIT | Out_Data valid; merge into ACC using opcode still on instr
// HALT    | terminal, everything frozen until rst
module bip_cpu #(
  parameter int PC_W   = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   pc_addr,
  input  logic [DATA_W-1:0] instr,
  output logic              Rd,
  output logic              Wr,
  output logic [PC_W-1:0]   address,
  output logic [DATA_W-1:0] In_Data,
  input  logic [DATA_W-1:0] Out_Data,
  output logic [DATA_W-1:0] acc,
  output logic              halted,
  output logic [31:0]       cycle_count
);

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  typedef enum logic [1:0] {
    EXEC    = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [PC_W-1:0]   pc, pc_nx;
  logic [DATA_W-1:0] acc_q, acc_nx;
  logic              rd_int, wr_int;
  logic [4:0]        opcode;
  logic [DATA_W-1:0] imm;

  assign opcode = instr[15:11];
  assign imm    = {{(DATA_W-PC_W){instr[PC_W-1]}}, instr[PC_W-1:0]};

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    acc_nx   = acc_q;
    rd_int   = 1'b0;
    wr_int   = 1'b0;
    case (state)
      EXEC: begin
        case (opcode)
          OP_HLT: state_nx = HALT;
          OP_STO: begin
            wr_int = 1'b1;
            pc_nx  = pc + 1'b1;
          end
          OP_LD, OP_ADD, OP_SUB: begin
            rd_int   = 1'b1;
            state_nx = MEMWAIT;
          end
          OP_LDI: begin
            acc_nx = imm;
            pc_nx  = pc + 1'b1;
          end
          OP_ADDI: begin
            acc_nx = acc_q + imm;
            pc_nx  = pc + 1'b1;
          end
          OP_SUBI: begin
            acc_nx = acc_q - imm;
            pc_nx  = pc + 1'b1;
          end
          default: pc_nx = pc + 1'b1;
        endcase
      end
      MEMWAIT: begin
        case (opcode)
          OP_LD:   acc_nx = Out_Data;
          OP_ADD:  acc_nx = acc_q + Out_Data;
          OP_SUB:  acc_nx = acc_q - Out_Data;
          default: acc_nx = acc_q;
        endcase
        pc_nx    = pc + 1'b1;
        state_nx = EXEC;
      end
      HALT:    state_nx = HALT;
      default: state_nx = EXEC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EXEC;
      pc    <= '0;
      acc_q <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      acc_q <= acc_nx;
    end
  end

`ifdef BIP_CYCLE_COUNT_EN
  logic [31:0] cc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q <= '0;
    end else if (state != HALT) begin
      cc_q <= cc_q + 32'd1;
    end
  end

  assign cycle_count = cc_q;
`else
  assign cycle_count = '0;
`endif

  // Strobes are masked by rst so nothing reaches memory during reset.
  assign Rd      = rd_int & ~rst;
  assign Wr      = wr_int & ~rst;
  assign pc_addr = pc;
  assign address = instr[PC_W-1:0];
  assign In_Data = acc_q;
  assign acc     = acc_q;
  assign halted  = (state == HALT);

endmodule

// File: tb/tb_bip_cpu.sv
// Directed bench for bip_cpu with a program ROM and a one-cycle-latency DataMemory model.
module tb_bip_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] pc_addr;
  logic [15:0] instr;
  logic        Rd, Wr;
  logic [10:0] address;
  logic [15:0] In_Data;
  logic [15:0] Out_Data = '0;
  logic [15:0] acc;
  logic        halted;
  logic [31:0] cycle_count;

  logic [15:0] prog [0:2047];
  logic [15:0] dmem [0:2047];
  logic        ovr_en = 1'b1;
  logic [15:0] ovr_val = 16'h1035;

  int total = 0;
  int passed = 0;

  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
  logic [10:0] wr_addr = '0;
  logic [15:0] wr_data = '0;

`ifdef BIP_CYCLE_COUNT_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  bip_cpu #(.PC_W(11), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .instr(instr),
    .Rd(Rd), .Wr(Wr), .address(address), .In_Data(In_Data),
    .Out_Data(Out_Data), .acc(acc), .halted(halted), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  always_comb instr = ovr_en ? ovr_val : prog[pc_addr];

  always @(posedge clk) begin
    if (Wr) dmem[address] <= In_Data;
    if (Rd) Out_Data <= dmem[address];
  end

  always @(negedge clk) begin
    if (Wr) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = address;
      wr_data = In_Data;
    end
    if (Rd) rd_cnt = rd_cnt + 1;
    if (Rd && Wr) both_cnt = both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_prog();
    for (int a = 0; a < 2048; a++) prog[a] = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int wb, rb, bb;
  logic [31:0] cc_snap;

  initial begin
    dmem[60] <= 16'hFFFF;
    dmem[61] <= 16'h0400;
    dmem[54] <= 16'hBEEF;
    clear_prog();

    // Reset with an LD word presented: no strobe may escape.
    tick(3);
    check("rst_pc", pc_addr, 0);
    check("rst_acc", acc, 0);
    check("rst_rd", Rd, 0);
    check("rst_wr", Wr, 0);
    check("rst_halted", halted, 0);
    check("rst_cc", cycle_count, 0);

    // Immediate arithmetic.
    prog[0] = 16'h1805; prog[1] = 16'h2FFF; prog[2] = 16'h3803; prog[3] = 16'h0000;
    ovr_en = 1'b0;
    rst = 1'b0;
    tick(1); check("imm_ldi", acc, 16'h0005); check("imm_pc1", pc_addr, 1);
    tick(1); check("imm_addi", acc, 16'h0004);
    tick(1); check("imm_subi", acc, 16'h0001);
    check("imm_not_halted", halted, 0);
    tick(1); check("imm_halted", halted, 1); check("imm_pc_hlt", pc_addr, 3);
    tick(3); check("imm_pc_frozen", pc_addr, 3); check("imm_acc_frozen", acc, 16'h0001);

    // Store/load round trip.
    clear_prog();
    prog[0] = 16'h187B; prog[1] = 16'h0835; prog[2] = 16'h1800; prog[3] = 16'h1035; prog[4] = 16'h0000;
    do_reset();
    wb = wr_cnt; rb = rd_cnt; bb = both_cnt;
    tick(1); check("sl_ldi", acc, 123);
    check("sl_wr_now", Wr, 1); check("sl_wr_addr", address, 53); check("sl_wr_data", In_Data, 123);
    tick(2); check("sl_ldi0", acc, 0); check("sl_rd_now", Rd, 1);
    tick(1); check("sl_memwait_rd", Rd, 0); check("sl_memwait_pc", pc_addr, 3);
    tick(1); check("sl_ld", acc, 123);
    tick(3);
    check("sl_halted", halted, 1);
    check("sl_wr_cycles", wr_cnt - wb, 1);
    check("sl_wr_addr_seen", wr_addr, 53);
    check("sl_wr_data_seen", wr_data, 123);
    check("sl_rd_cycles", rd_cnt - rb, 1);
    check("sl_mem53", dmem[53], 123);
    check("sl_cc", cycle_count, CC_EN ? 32'd6 : 32'd0);

    // Modulo-2^16 wrap through ADD and SUB.
    clear_prog();
    prog[0] = 16'h1BFF; prog[1] = 16'h203C; prog[2] = 16'h303D; prog[3] = 16'h0000;
    do_reset();
    tick(1); check("wrap_ldi", acc, 16'h03FF);
    tick(2); check("wrap_add", acc, 16'h03FE);
    tick(2); check("wrap_sub", acc, 16'hFFFE);
    check("wrap_pc", pc_addr, 3);

    // Reset during MEMWAIT discards the pending load.
    clear_prog();
    prog[0] = 16'h1807; prog[1] = 16'h1036; prog[2] = 16'h0000;
    do_reset();
    tick(1); check("ml_ldi", acc, 7); check("ml_rd_issue", Rd, 1);
    tick(1); check("ml_in_memwait_pc", pc_addr, 1);
    rst = 1'b1;
    tick(1);
    check("ml_acc_cleared", acc, 0); check("ml_pc_cleared", pc_addr, 0); check("ml_rd", Rd, 0);
    rst = 1'b0;
    tick(1); check("ml_after_ldi", acc, 7);
    tick(2); check("ml_after_ld", acc, 16'hBEEF);

    // Unknown opcode, then HLT, then hammer instr while halted.
    clear_prog();
    prog[0] = 16'h1809; prog[1] = 16'hF955; prog[2] = 16'h0000;
    do_reset();
    tick(1); check("nop_pre", acc, 9);
    wb = wr_cnt; rb = rd_cnt;
    tick(1); check("nop_pc", pc_addr, 2); check("nop_acc", acc, 9);
    check("nop_strobes", (wr_cnt - wb) + (rd_cnt - rb), 0);
    tick(1); check("nop_halted", halted, 1);
    cc_snap = cycle_count;
    check("nop_cc", cycle_count, CC_EN ? 32'd3 : 32'd0);
    wb = wr_cnt; rb = rd_cnt;
    ovr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      case (i % 4)
        0: ovr_val = 16'h0835;
        1: ovr_val = 16'h1035;
        2: ovr_val = 16'h2036;
        default: ovr_val = 16'h1800 | 16'($urandom_range(0, 2047));
      endcase
      tick(1);
    end
    check("halt_wr", wr_cnt - wb, 0);
    check("halt_rd", rd_cnt - rb, 0);
    check("halt_pc", pc_addr, 2);
    check("halt_acc", acc, 9);
    check("halt_cc", cycle_count, cc_snap);
    check("halt_state", halted, 1);
    check("never_both", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
